fir_post_decim: RTL and testbench
=================================

FIR_POST_DECIM -- requirements
Module: fir_post_decim

Interface
REQ-001 Parameters SHALL be as follows.
- pDATA_WIDTH, default 32: input sample width, signed.
- pOUT_WIDTH, default 16: output sample width, signed.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 The ports SHALL be as follows.
- axis_clk, in, 1: clock.
- axis_rst_n, in, 1: synchronous active-low reset.
- ss_tvalid, in, 1: input beat valid.
- ss_tdata, in, pDATA_WIDTH: FIR output sample.
- ss_tlast, in, 1: last sample of frame.
- ss_tready, out, 1: input accept.
- sm_tvalid, out, 1: output beat valid.
- sm_tdata, out, pOUT_WIDTH: decimated, scaled sample.
- sm_tlast, out, 1: last output of frame.
- sm_tready, in, 1: downstream accept.
- cfg_decim, in, 4: decimation factor minus 1 (factor 1..16).
- cfg_shift, in, 5: arithmetic right shift 0..31.
- sat_cnt, out, 16: saturated-output count, saturating at 16'hFFFF.
- out_cnt, out, 16: emitted beats in current/last frame.
- frame_done, out, 1: one-cycle pulse after the tlast output handshake.

Function
REQ-004 An input beat SHALL be accepted on a rising edge when ss_tvalid && ss_tready.
REQ-005 ss_tready SHALL be rst_done_q && (fifo_count < 2), where rst_done_q is a register cleared by reset and set on the first cycle after reset release; no combinational path from sm_tready.
REQ-006 The output buffer SHALL be a 2-entry FIFO; sm_tvalid = (fifo_count != 0); sm_tdata and sm_tlast SHALL come from the FIFO head.
REQ-007 Push and pop in the same cycle SHALL leave fifo_count unchanged; with sm_tready held high, throughput SHALL be 1 beat/cycle.
REQ-008 Latency SHALL be 1 cycle: a kept beat accepted at edge N SHALL be visible on sm_tvalid after edge N.
REQ-009 Frame state SHALL be IDLE or ACTIVE:
- The first accepted beat in IDLE SHALL latch cfg_decim/cfg_shift, clear out_cnt and go ACTIVE.
- The accepted ss_tlast beat SHALL return to IDLE.
- Config changes while ACTIVE SHALL be ignored.
REQ-010 A phase counter SHALL behave as follows:
- Counts accepted beats 0..decim_q, wrapping to 0.
- A beat is kept when phase==0.
- A beat with ss_tlast=1 is always kept, carries sm_tlast=1 and resets phase to 0.
REQ-011 decim_q=0 SHALL keep every beat (pass-through).
REQ-012 Scaling SHALL be computed in pDATA_WIDTH+1 bits: y = (x + (shift_q>0 ? 2^(shift_q-1) : 0)) >>> shift_q, i.e. round-half-up.
REQ-013 y SHALL saturate to [-2^(pOUT_WIDTH-1), 2^(pOUT_WIDTH-1)-1]; each kept saturated beat SHALL increment sat_cnt.
REQ-014 out_cnt SHALL increment on each kept beat pushed into the FIFO.
REQ-015 frame_done SHALL pulse for exactly 1 cycle following the sm handshake whose sm_tlast=1.
REQ-016 Discarded beats SHALL never enter the FIFO or affect sat_cnt/out_cnt.

Reset
REQ-017 While axis_rst_n=0 at a clock edge, the following SHALL be cleared:
- ss_tready=0, sm_tvalid=0, sm_tdata=0, sm_tlast=0.
- sat_cnt=0, out_cnt=0, frame_done=0.
- fifo_count=0, phase=0, state=IDLE.
REQ-018 Reset mid-frame SHALL discard all buffered beats with no partial output after release.

Structure
REQ-019 A shared package SHALL hold the frame-state enum (IDLE, ACTIVE), FIFO depth constant 2 and counter width 16.
REQ-020 The scale/round/saturate datapath SHALL be one combinational sub-module, fir_post_scale.

Verification
REQ-021 The bench SHALL cover these scenarios:
- decim=0, shift=0, inputs 1..5, tlast on 5, sm_tready=1 -> outputs 1,2,3,4,5 on consecutive cycles, tlast on 5, latency 1, frame_done pulse.
- decim=2, shift=0, inputs 0..9, tlast on 9 -> outputs 0,3,6,9, tlast on 9, out_cnt=4.
- decim=0, shift=4, inputs 40, -40, 24 -> outputs 3, -2, 2.
- shift=0, inputs 32'h0001_0000 and -100000 -> outputs 32767 and -32768, sat_cnt=2.
- sm_tready=0 for 6 cycles, continuous input -> ss_tready low after 2 accepts, then all samples delivered in order with no loss or duplication.
- axis_rst_n low for 2 cycles after 3 beats of a frame -> sm_tvalid=0 and counters 0; next frame restarts at phase 0 with new cfg.

Source files
------------

// File: rtl/fir_post_decim_pkg.sv
// fir_post_decim_pkg: shared frame-state type and sizing constants
package fir_post_decim_pkg;
  typedef enum logic {IDLE, ACTIVE} frame_state_e;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = 16;
endpackage

// File: rtl/fir_post_scale.sv
// fir_post_scale: round-half-up arithmetic right shift with signed saturation
module fir_post_scale #(
  parameter int pDATA_WIDTH = 32,
  parameter int pOUT_WIDTH = 16
) (
  input  logic [pDATA_WIDTH-1:0] x_i,
  input  logic [4:0]             shift_i,
  output logic [pOUT_WIDTH-1:0]  y_o,
  output logic                   sat_o
);
  localparam logic signed [pDATA_WIDTH:0] MAX = {{(pDATA_WIDTH-pOUT_WIDTH+2){1'b0}}, {(pOUT_WIDTH-1){1'b1}}};
  localparam logic signed [pDATA_WIDTH:0] MIN = ~MAX;
  logic signed [pDATA_WIDTH:0] ext, rnd, sum, sh;
  logic hi, lo;
  // one extra bit keeps the rounding add from overflowing
  always_comb begin
    ext = {x_i[pDATA_WIDTH-1], x_i};
    rnd = shift_i == '0 ? '0 : (pDATA_WIDTH+1)'(1) << (shift_i - 5'd1);
    sum = ext + rnd;
    sh = sum >>> shift_i;
    hi = sh > MAX;
    lo = sh < MIN;
    sat_o = hi || lo;
    y_o = hi ? {1'b0, {(pOUT_WIDTH-1){1'b1}}} : lo ? {1'b1, {(pOUT_WIDTH-1){1'b0}}} : sh[pOUT_WIDTH-1:0];
  end
endmodule

// File: rtl/fir_post_decim.sv
// fir_post_decim: frame-aware decimator with scaling and a 2-entry output FIFO
module fir_post_decim
  import fir_post_decim_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pOUT_WIDTH = 16
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pOUT_WIDTH-1:0]  sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  input  logic [3:0]             cfg_decim,
  input  logic [4:0]             cfg_shift,
  output logic [CNT_W-1:0]       sat_cnt,
  output logic [CNT_W-1:0]       out_cnt,
  output logic                   frame_done
);
  logic rst_done_q, rd_q, wr_q, done_q;
  frame_state_e state_q;
  logic [3:0] decim_q, phase_q, decim_eff, phase_d;
  logic [4:0] shift_q, shift_eff;
  logic [1:0] count_q, count_d;
  logic [pOUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_q;
  logic [CNT_W-1:0] sat_q, out_q;
  logic idle, acc, keep, push, pop, sat;
  logic [pOUT_WIDTH-1:0] y;

  fir_post_scale #(.pDATA_WIDTH(pDATA_WIDTH), .pOUT_WIDTH(pOUT_WIDTH)) u_scale (
    .x_i(ss_tdata), .shift_i(shift_eff), .y_o(y), .sat_o(sat)
  );

  // the opening beat of a frame already uses the live config it latches
  always_comb begin
    idle = state_q == IDLE;
    decim_eff = idle ? cfg_decim : decim_q;
    shift_eff = idle ? cfg_shift : shift_q;
    ss_tready = rst_done_q && count_q != 2'(FIFO_DEPTH);
    sm_tvalid = count_q != '0;
    sm_tdata = mem_q[rd_q];
    sm_tlast = last_q[rd_q];
    acc = ss_tvalid && ss_tready;
    keep = phase_q == '0 || ss_tlast;
    push = acc && keep;
    pop = sm_tvalid && sm_tready;
    phase_d = (ss_tlast || phase_q == decim_eff) ? '0 : phase_q + 4'd1;
    count_d = count_q + 2'(push) - 2'(pop);
    sat_cnt = sat_q;
    out_cnt = out_q;
    frame_done = done_q;
  end

  // frame tracking, FIFO storage and statistics
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      rst_done_q <= 1'b0;
      state_q <= IDLE;
      decim_q <= '0;
      shift_q <= '0;
      phase_q <= '0;
      count_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      mem_q <= '{default: '0};
      last_q <= '0;
      sat_q <= '0;
      out_q <= '0;
      done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      count_q <= count_d;
      done_q <= pop && sm_tlast;
      if (pop) rd_q <= ~rd_q;
      if (push) begin
        mem_q[wr_q] <= y;
        last_q[wr_q] <= ss_tlast;
        wr_q <= ~wr_q;
        if (sat && sat_q != '1) sat_q <= sat_q + 1'b1;
      end
      if (acc) begin
        phase_q <= phase_d;
        state_q <= ss_tlast ? IDLE : ACTIVE;
        if (idle) begin
          decim_q <= cfg_decim;
          shift_q <= cfg_shift;
        end
      end
      if (acc && idle) out_q <= CNT_W'(push);
      else if (push) out_q <= out_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_post_decim.sv
// tb_fir_post_decim: randomized scoreboard bench for fir_post_decim
module tb_fir_post_decim;
  logic axis_clk = 0, axis_rst_n = 0, ss_tvalid = 0, ss_tlast = 0, sm_tready = 0;
  logic [31:0] ss_tdata = 0;
  logic [3:0] cfg_decim = 0;
  logic [4:0] cfg_shift = 0;
  logic ss_tready, sm_tvalid, sm_tlast, frame_done;
  logic [15:0] sm_tdata, sat_cnt, out_cnt;

  fir_post_decim dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .cfg_decim(cfg_decim), .cfg_shift(cfg_shift),
    .sat_cnt(sat_cnt), .out_cnt(out_cnt), .frame_done(frame_done)
  );

  always #5 axis_clk = ~axis_clk;

  typedef struct packed {logic [15:0] d; logic l;} beat_t;
  beat_t sbq[$];
  beat_t e;
  int tests = 0, fails = 0;
  bit stall = 0, rnd_bp = 0, in_rst = 1, fd_exp = 0;
  bit m_active = 0;
  int m_decim = 0, m_shift = 0, m_idx = 0, m_out = 0, m_sat = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mscale(input longint x, input int s, output bit sat);
    longint v;
    v = x + (s > 0 ? (longint'(1) << (s - 1)) : 0);
    v = v >>> s;
    sat = v > 32767 || v < -32768;
    return sat ? (v > 0 ? 16'h7fff : 16'h8000) : 16'(v);
  endfunction

  task automatic model_accept(input logic [31:0] x, input bit last);
    bit s;
    logic [15:0] y;
    if (!m_active) begin
      m_active = 1;
      m_decim = int'(cfg_decim);
      m_shift = int'(cfg_shift);
      m_idx = 0;
      m_out = 0;
    end
    if (m_idx % (m_decim + 1) == 0 || last) begin
      y = mscale(longint'($signed(x)), m_shift, s);
      sbq.push_back('{d: y, l: last});
      m_out++;
      if (s && m_sat < 65535) m_sat++;
    end
    m_idx++;
    if (last) m_active = 0;
  endtask

  task automatic send(input logic [31:0] x, input bit last, input bit lat);
    int n = 0;
    ss_tdata = x;
    ss_tlast = last;
    ss_tvalid = 1;
    while (!ss_tready && n < 100) begin
      @(negedge axis_clk);
      n++;
    end
    if (!ss_tready) begin
      tests++;
      fails++;
      $display("FAIL ss_tready_timeout: got 0 expected 1");
      ss_tvalid = 0;
      return;
    end
    model_accept(x, last);
    @(negedge axis_clk);
    if (lat) check("latency_valid", sm_tvalid, 1);
    ss_tvalid = 0;
    ss_tlast = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || sm_tvalid) && n < 300) begin
      @(negedge axis_clk);
      n++;
    end
    check("drain_left", sbq.size(), 0);
    check("out_cnt", out_cnt, m_out);
    check("sat_cnt", sat_cnt, m_sat);
  endtask

  task automatic rst_checks();
    check("rst_ss_tready", ss_tready, 0);
    check("rst_sm_tvalid", sm_tvalid, 0);
    check("rst_sm_tdata", sm_tdata, 0);
    check("rst_sm_tlast", sm_tlast, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_out_cnt", out_cnt, 0);
    check("rst_frame_done", frame_done, 0);
  endtask

  task automatic do_reset();
    @(posedge axis_clk);
    #2 in_rst = 1;
    axis_rst_n = 0;
    @(negedge axis_clk);
    sbq.delete();
    m_active = 0;
    m_out = 0;
    m_sat = 0;
    @(negedge axis_clk);
    rst_checks();
    axis_rst_n = 1;
    in_rst = 0;
  endtask

  initial forever begin
    @(posedge axis_clk);
    #1 sm_tready = stall ? 1'b0 : rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge axis_clk) begin
    if (in_rst) fd_exp = 0;
    else begin
      if (fd_exp || frame_done) check("frame_done", frame_done, fd_exp);
      fd_exp = sm_tvalid && sm_tready && sm_tlast;
      if (sm_tvalid && sm_tready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0d expected none", $signed(sm_tdata));
        end else begin
          e = sbq.pop_front();
          check("sm_tdata", $signed(sm_tdata), $signed(e.d));
          check("sm_tlast", sm_tlast, e.l);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge axis_clk);
    rst_checks();
    axis_rst_n = 1;
    in_rst = 0;
    @(negedge axis_clk);
    cfg_decim = 0;
    cfg_shift = 0;
    for (int i = 1; i <= 5; i++) send(32'(i), i == 5, 1);
    drain();
    cfg_decim = 2;
    for (int i = 0; i <= 9; i++) send(32'(i), i == 9, 0);
    drain();
    check("decim2_out_cnt", out_cnt, 4);
    cfg_decim = 0;
    cfg_shift = 4;
    send(32'd40, 0, 0);
    send(-32'sd40, 0, 0);
    send(32'd24, 1, 0);
    drain();
    cfg_shift = 0;
    send(32'h0001_0000, 0, 0);
    send(-32'sd100000, 1, 0);
    drain();
    check("sat_cnt_two", sat_cnt, 2);
    stall = 1;
    @(negedge axis_clk);
    send(32'd100, 0, 0);
    send(32'd101, 0, 0);
    check("bp_ss_tready", ss_tready, 0);
    repeat (4) @(negedge axis_clk);
    stall = 0;
    for (int i = 2; i < 8; i++) send(32'(100 + i), i == 7, 0);
    drain();
    cfg_decim = 1;
    stall = 1;
    @(negedge axis_clk);
    for (int i = 0; i < 3; i++) send(32'(200 + i), 0, 0);
    check("pre_rst_valid", sm_tvalid, 1);
    do_reset();
    stall = 0;
    cfg_decim = 2;
    cfg_shift = 1;
    for (int i = 0; i < 7; i++) send(32'(10 * i + 1), i == 6, 0);
    drain();
    rnd_bp = 1;
    for (int f = 0; f < 20; f++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        cfg_decim = 4'($urandom_range(0, 15));
        cfg_shift = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 4) == 0) @(negedge axis_clk);
        send($urandom_range(0, 1) != 0 ? $urandom : 32'($signed($urandom_range(0, 200000)) - 100000), i == len - 1, 0);
      end
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
